// File: rtl/scbuf_dram_pkg.sv
// scbuf_dram_pkg: shared widths, buffer entry type and serializer states
package scbuf_dram_pkg;
  localparam int LINE_W = 512;
  localparam int BEAT_W = 64;
  localparam int BEATS = 8;
  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              mecc;
  } wr_entry_t;
  typedef enum logic {IDLE, STREAM} ser_state_t;
endpackage

// File: rtl/scbuf_wr_line_fifo.sv
// scbuf_wr_line_fifo: circular line buffer exposing the head and the entry behind it
module scbuf_wr_line_fifo
  import scbuf_dram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wr_entry_t din,
  output wr_entry_t head,
  output wr_entry_t nxt,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  wr_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp, rp1;
  logic [AW:0] cnt;
  assign rp1 = rp + AW'(1);
  assign head = mem[rp];
  assign nxt = mem[rp1];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  // pointer, occupancy and storage update; push and pop may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wp] <= din;
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/scbuf_dram_wr_ser.sv
// scbuf_dram_wr_ser: buffers evicted lines, requests dram writes, streams 8 beats per ack
module scbuf_dram_wr_ser
  import scbuf_dram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              line_vld,
  input  logic [LINE_W-1:0] line_data,
  input  logic              line_mecc,
  output logic              line_rdy,
  output logic              sctag_dram_wr_req,
  input  logic              dram_sctag_wr_ack,
  output logic [BEAT_W-1:0] scbuf_dram_wr_data_r5,
  output logic              scbuf_dram_data_vld_r5,
  output logic              scbuf_dram_data_mecc_r5,
  output logic              ack_err,
  output logic              busy
);
  localparam int CW = $clog2(DEPTH + 1);
  ser_state_t state;
  logic [2:0] beat, nb;
  logic [CW-1:0] req_out, pend_ack;
  wr_entry_t head, nxt, src;
  logic full, empty, push, ack_ok, last, cont, start;
  // the next entry is read from behind the head when chaining, since the head frees on the same edge
  always_comb begin
    push = line_vld & ~full;
    ack_ok = dram_sctag_wr_ack & ((req_out != '0) | sctag_dram_wr_req);
    last = (state == STREAM) && (beat == 3'(BEATS - 1));
    cont = (state == STREAM) && !last;
    start = ((pend_ack != '0) | ack_ok) & ((state == IDLE) | last);
    nb = cont ? beat + 3'd1 : 3'd0;
    src = last ? nxt : head;
  end
  assign line_rdy = ~full;
  assign busy = ~empty | (state == STREAM);
  scbuf_wr_line_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (rclk),
    .rst   (rst),
    .push  (push),
    .pop   (last),
    .din   ('{data: line_data, mecc: line_mecc}),
    .head  (head),
    .nxt   (nxt),
    .full  (full),
    .empty (empty)
  );
  // request pulse, outstanding/pending ack bookkeeping and sticky spurious-ack flag
  always_ff @(posedge rclk) begin
    if (rst) begin
      sctag_dram_wr_req <= 1'b0;
      req_out <= '0;
      pend_ack <= '0;
      ack_err <= 1'b0;
    end else begin
      sctag_dram_wr_req <= push;
      req_out <= req_out + CW'(sctag_dram_wr_req) - CW'(ack_ok);
      pend_ack <= pend_ack + CW'(ack_ok) - CW'(start);
      ack_err <= ack_err | (dram_sctag_wr_ack & ~ack_ok);
    end
  end
  // serializer FSM with registered beat, valid and poison outputs
  always_ff @(posedge rclk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      scbuf_dram_wr_data_r5 <= '0;
      scbuf_dram_data_vld_r5 <= 1'b0;
      scbuf_dram_data_mecc_r5 <= 1'b0;
    end else if (cont | start) begin
      state <= STREAM;
      beat <= nb;
      scbuf_dram_wr_data_r5 <= src.data[nb*BEAT_W +: BEAT_W];
      scbuf_dram_data_vld_r5 <= 1'b1;
      scbuf_dram_data_mecc_r5 <= src.mecc;
    end else begin
      state <= IDLE;
      beat <= '0;
      scbuf_dram_data_vld_r5 <= 1'b0;
      scbuf_dram_data_mecc_r5 <= 1'b0;
    end
  end
endmodule

// File: tb/tb_scbuf_dram_wr_ser.sv
// tb_scbuf_dram_wr_ser: directed checks of request, streaming, full, poison, spurious ack and reset
module tb_scbuf_dram_wr_ser;
  logic rclk = 0, rst = 1, line_vld = 0, line_mecc = 0, ack = 0;
  logic [511:0] line_data = '0;
  logic line_rdy, wr_req, vld, mecc, ack_err, busy;
  logic [63:0] data;
  int n_chk = 0, n_fail = 0;
  localparam logic [63:0] B0 = 64'h0000_0000_0000_0007, B1 = 64'hA100_0000_0000_0000,
    B2 = 64'hB200_0000_0000_0000, B3 = 64'hC300_0000_0000_0000, B4 = 64'hD400_0000_0000_0000,
    B5 = 64'hE500_0000_0000_0000, B6 = 64'hF600_0000_0000_0000;
  scbuf_dram_wr_ser #(.DEPTH(2)) dut (
    .rclk(rclk), .rst(rst), .line_vld(line_vld), .line_data(line_data), .line_mecc(line_mecc),
    .line_rdy(line_rdy), .sctag_dram_wr_req(wr_req), .dram_sctag_wr_ack(ack),
    .scbuf_dram_wr_data_r5(data), .scbuf_dram_data_vld_r5(vld), .scbuf_dram_data_mecc_r5(mecc),
    .ack_err(ack_err), .busy(busy)
  );
  always #5 rclk = ~rclk;
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge rclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] wd(input logic [63:0] b, input int k);
    return b + 64'(k) * 64'h1111;
  endfunction
  function automatic logic [511:0] mk(input logic [63:0] b);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[64*k +: 64] = wd(b, k);
    return r;
  endfunction
  task automatic beat(input string tag, input logic [63:0] b, input int k, input logic m);
    chk({tag, "_data"}, data, wd(b, k));
    chk({tag, "_vld"}, 64'(vld), 64'd1);
    chk({tag, "_mecc"}, 64'(mecc), 64'(m));
  endtask
  initial begin
    logic [63:0] b;
    tick;
    tick;
    rst = 0;
    chk("rst_rdy", 64'(line_rdy), 64'd1);
    chk("rst_req", 64'(wr_req), 64'd0);
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_mecc", 64'(mecc), 64'd0);
    chk("rst_ackerr", 64'(ack_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", data, 64'd0);
    line_vld = 1;
    line_data = mk(B0);
    tick;
    line_vld = 0;
    chk("single_req", 64'(wr_req), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    tick;
    chk("single_req_end", 64'(wr_req), 64'd0);
    chk("single_novld", 64'(vld), 64'd0);
    tick;
    tick;
    ack = 1;
    tick;
    ack = 0;
    for (int k = 0; k < 8; k++) begin
      beat("single", B0, k, 0);
      chk("single_rdy", 64'(line_rdy), 64'd1);
      tick;
    end
    chk("single_idle_vld", 64'(vld), 64'd0);
    chk("single_hold", data, wd(B0, 7));
    chk("single_idle_busy", 64'(busy), 64'd0);
    line_vld = 1;
    line_data = mk(B1);
    tick;
    chk("b2b_req0", 64'(wr_req), 64'd1);
    line_data = mk(B2);
    tick;
    line_vld = 0;
    chk("b2b_req1", 64'(wr_req), 64'd1);
    chk("b2b_full", 64'(line_rdy), 64'd0);
    tick;
    chk("b2b_req_end", 64'(wr_req), 64'd0);
    ack = 1;
    tick;
    ack = 0;
    for (int i = 0; i < 16; i++) begin
      b = i < 8 ? B1 : B2;
      beat("b2b", b, i % 8, 0);
      ack = i == 1;
      tick;
      ack = 0;
    end
    chk("b2b_idle_vld", 64'(vld), 64'd0);
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    line_vld = 1;
    line_mecc = 1;
    line_data = mk(B3);
    tick;
    line_mecc = 0;
    line_data = mk(B4);
    tick;
    line_data = mk(B5);
    chk("full_rdy", 64'(line_rdy), 64'd0);
    chk("full_req", 64'(wr_req), 64'd1);
    ack = 1;
    tick;
    for (int i = 0; i < 24; i++) begin
      b = i < 8 ? B3 : (i < 16 ? B4 : B5);
      beat("stream", b, i % 8, i < 8);
      chk("stream_rdy", 64'(line_rdy), 64'(i == 8 || i >= 16));
      if (i == 9) chk("stream_req", 64'(wr_req), 64'd1);
      ack = i == 0 || i == 9;
      tick;
      ack = 0;
      if (i == 8) line_vld = 0;
    end
    chk("stream_idle_vld", 64'(vld), 64'd0);
    chk("stream_idle_busy", 64'(busy), 64'd0);
    chk("stream_ackerr", 64'(ack_err), 64'd0);
    ack = 1;
    tick;
    ack = 0;
    chk("spur_err", 64'(ack_err), 64'd1);
    chk("spur_vld", 64'(vld), 64'd0);
    tick;
    tick;
    chk("spur_sticky", 64'(ack_err), 64'd1);
    chk("spur_vld_late", 64'(vld), 64'd0);
    rst = 1;
    tick;
    rst = 0;
    chk("rst2_ackerr", 64'(ack_err), 64'd0);
    line_vld = 1;
    line_data = mk(B6);
    tick;
    line_vld = 0;
    ack = 1;
    tick;
    ack = 0;
    for (int k = 0; k < 4; k++) begin
      beat("mid", B6, k, 0);
      if (k < 3) tick;
    end
    rst = 1;
    tick;
    rst = 0;
    chk("mid_vld", 64'(vld), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_rdy", 64'(line_rdy), 64'd1);
    chk("mid_mecc", 64'(mecc), 64'd0);
    tick;
    tick;
    chk("mid_vld_late", 64'(vld), 64'd0);
    ack = 1;
    tick;
    ack = 0;
    chk("mid_ackerr", 64'(ack_err), 64'd1);
    chk("mid_ack_vld", 64'(vld), 64'd0);
    tick;
    chk("mid_ack_vld_late", 64'(vld), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
